// File: rtl/axi_chk_pkg.sv
// Shared constants for the AXI read-side RLAST checker.
package axi_chk_pkg;
  localparam int unsigned AXI_LEN_W        = 8;
  localparam int unsigned ERR_W            = 4;
  localparam int unsigned ERR_EARLY_LAST   = 0;
  localparam int unsigned ERR_MISSING_LAST = 1;
  localparam int unsigned ERR_OVERFLOW     = 2;
  localparam int unsigned ERR_UNEXPECTED   = 3;
endpackage

// File: rtl/burst_len_fifo.sv
// Synchronous FIFO of outstanding burst lengths; head is presented combinationally.
module burst_len_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/axi_rlast_checker.sv
// Passive AXI read monitor: queues ARLEN, checks RLAST placement, pulses per closed burst.
// Optional RLAST_CHK_STATS_EN adds good-burst and accepted-beat counters.
module axi_rlast_checker
  import axi_chk_pkg::*;
#(
  parameter int unsigned LEN_W = AXI_LEN_W,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_ar_valid,
  input  logic                   i_ar_ready,
  input  logic [LEN_W-1:0]       i_ar_len,
  input  logic                   i_r_valid,
  input  logic                   i_r_ready,
  input  logic                   i_r_last,
  output logic                   o_ar_block,
  output logic                   o_burst_done,
  output logic [CNT_W-1:0]       o_beat_cnt,
  output logic [$clog2(DEPTH):0] o_outstanding,
`ifdef RLAST_CHK_STATS_EN
  output logic [31:0]            o_stat_bursts,
  output logic [31:0]            o_stat_beats,
`endif
  output logic [ERR_W-1:0]       o_err
);
  localparam int unsigned OUT_W = $clog2(DEPTH) + 1;

  logic             w_ar_hs, w_r_hs, w_beat_ok, w_at_last, w_good;
  logic             w_push, w_pop;
  logic             w_full, w_empty;
  logic [LEN_W-1:0] w_head;
  logic [OUT_W-1:0] w_count, w_count_nxt;
  logic [ERR_W-1:0] w_err_set;

  logic             r_ar_block;
  logic             r_burst_done;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [ERR_W-1:0] r_err;

  burst_len_fifo #(.WIDTH(LEN_W), .DEPTH(DEPTH)) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (i_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_ar_len),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Empty is sampled before this cycle's push, so a same-cycle AR never feeds the R side.
  always_comb begin
    w_ar_hs   = i_ar_valid & i_ar_ready;
    w_r_hs    = i_r_valid & i_r_ready;
    w_beat_ok = w_r_hs & ~w_empty;
    w_at_last = (r_beat_cnt == CNT_W'(w_head));
    w_pop     = w_beat_ok & (i_r_last | w_at_last);
    w_good    = w_beat_ok & i_r_last & w_at_last;
    w_push    = w_ar_hs & (~w_full | w_pop);
    w_count_nxt = w_count + OUT_W'(w_push) - OUT_W'(w_pop);
    w_err_set = '0;
    w_err_set[ERR_EARLY_LAST]   = w_beat_ok & i_r_last & ~w_at_last;
    w_err_set[ERR_MISSING_LAST] = w_beat_ok & ~i_r_last & w_at_last;
    w_err_set[ERR_OVERFLOW]     = w_ar_hs & w_full & ~w_pop;
    w_err_set[ERR_UNEXPECTED]   = w_r_hs & w_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar_block   <= 1'b0;
      r_burst_done <= 1'b0;
      r_beat_cnt   <= '0;
      r_err        <= '0;
    end else if (i_start) begin
      r_ar_block   <= 1'b0;
      r_burst_done <= 1'b0;
      r_beat_cnt   <= '0;
      r_err        <= '0;
    end else begin
      r_ar_block   <= (w_count_nxt == OUT_W'(DEPTH));
      r_burst_done <= w_pop;
      r_err        <= r_err | w_err_set;
      if (w_pop)          r_beat_cnt <= '0;
      else if (w_beat_ok) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

`ifdef RLAST_CHK_STATS_EN
  logic [31:0] r_stat_bursts;
  logic [31:0] r_stat_beats;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_bursts <= '0;
      r_stat_beats  <= '0;
    end else if (i_start) begin
      r_stat_bursts <= '0;
      r_stat_beats  <= '0;
    end else begin
      if (w_good)    r_stat_bursts <= r_stat_bursts + 32'd1;
      if (w_beat_ok) r_stat_beats  <= r_stat_beats + 32'd1;
    end
  end

  assign o_stat_bursts = r_stat_bursts;
  assign o_stat_beats  = r_stat_beats;
`endif

  assign o_ar_block    = r_ar_block;
  assign o_burst_done  = r_burst_done;
  assign o_beat_cnt    = r_beat_cnt;
  assign o_outstanding = w_count;
  assign o_err         = r_err;
endmodule

// File: tb/tb_axi_rlast_checker.sv
// Directed bench for axi_rlast_checker with hand-computed expectations.
module tb_axi_rlast_checker;
  logic       clk;
  logic       rst;
  logic       i_start;
  logic       i_ar_valid, i_ar_ready;
  logic [7:0] i_ar_len;
  logic       i_r_valid, i_r_ready, i_r_last;
  logic       o_ar_block, o_burst_done;
  logic [7:0] o_beat_cnt;
  logic [3:0] o_outstanding;
  logic [3:0] o_err;
`ifdef RLAST_CHK_STATS_EN
  logic [31:0] o_stat_bursts, o_stat_beats;
`endif

  int n_cmp;
  int n_fail;

  axi_rlast_checker #(.LEN_W(8), .DEPTH(8), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_ar_valid    (i_ar_valid),
    .i_ar_ready    (i_ar_ready),
    .i_ar_len      (i_ar_len),
    .i_r_valid     (i_r_valid),
    .i_r_ready     (i_r_ready),
    .i_r_last      (i_r_last),
    .o_ar_block    (o_ar_block),
    .o_burst_done  (o_burst_done),
    .o_beat_cnt    (o_beat_cnt),
    .o_outstanding (o_outstanding),
`ifdef RLAST_CHK_STATS_EN
    .o_stat_bursts (o_stat_bursts),
    .o_stat_beats  (o_stat_beats),
`endif
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Set up the next cycle's handshakes; both readies held high.
  task automatic drive(input logic arv, input logic [7:0] len, input logic rv, input logic last);
    i_ar_valid = arv;
    i_ar_ready = 1'b1;
    i_ar_len   = len;
    i_r_valid  = rv;
    i_r_ready  = 1'b1;
    i_r_last   = last;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    i_start = 1'b0;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    cyc();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    clk = 1'b0;
    rst = 1'b1;
    i_start = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    #1;
    chk("rst_beat_cnt", 32'(o_beat_cnt), 32'd0);
    chk("rst_outstanding", 32'(o_outstanding), 32'd0);
    chk("rst_burst_done", 32'(o_burst_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_ar_block", 32'(o_ar_block), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Good 4-beat burst
    drive(1'b1, 8'd3, 1'b0, 1'b0); cyc();
    chk("t1_out1", 32'(o_outstanding), 32'd1);
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    chk("t1_cnt1", 32'(o_beat_cnt), 32'd1);
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    chk("t1_cnt3", 32'(o_beat_cnt), 32'd3);
    chk("t1_no_done", 32'(o_burst_done), 32'd0);
    drive(1'b0, 8'd0, 1'b1, 1'b1); cyc();
    chk("t1_done", 32'(o_burst_done), 32'd1);
    chk("t1_cnt0", 32'(o_beat_cnt), 32'd0);
    chk("t1_out0", 32'(o_outstanding), 32'd0);
    chk("t1_err", 32'(o_err), 32'd0);
    cyc();
    chk("t1_done_pulse", 32'(o_burst_done), 32'd0);

    // Early last on beat 3 of an 8-beat burst
    drive(1'b1, 8'd7, 1'b0, 1'b0); cyc();
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    drive(1'b0, 8'd0, 1'b1, 1'b1); cyc();
    chk("t2_err", 32'(o_err), 32'h1);
    chk("t2_done", 32'(o_burst_done), 32'd1);
    chk("t2_cnt", 32'(o_beat_cnt), 32'd0);
    chk("t2_out", 32'(o_outstanding), 32'd0);
    do_start();
    chk("t2_start_err", 32'(o_err), 32'd0);

    // Missing last then resync onto a single-beat burst
    drive(1'b1, 8'd1, 1'b0, 1'b0); cyc();
    drive(1'b1, 8'd0, 1'b0, 1'b0); cyc();
    chk("t3_out2", 32'(o_outstanding), 32'd2);
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    chk("t3_cnt1", 32'(o_beat_cnt), 32'd1);
    chk("t3_err_none", 32'(o_err), 32'd0);
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    chk("t3_err_miss", 32'(o_err), 32'h2);
    chk("t3_done1", 32'(o_burst_done), 32'd1);
    chk("t3_out1", 32'(o_outstanding), 32'd1);
    chk("t3_cnt0", 32'(o_beat_cnt), 32'd0);
    drive(1'b0, 8'd0, 1'b1, 1'b1); cyc();
    chk("t3_done2", 32'(o_burst_done), 32'd1);
    chk("t3_out0", 32'(o_outstanding), 32'd0);
    chk("t3_err_keep", 32'(o_err), 32'h2);
    do_start();

    // Fill the queue with single-beat bursts
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'd0, 1'b0, 1'b0); cyc();
    end
    chk("t4_out7", 32'(o_outstanding), 32'd7);
    chk("t4_block7", 32'(o_ar_block), 32'd0);
    drive(1'b1, 8'd0, 1'b0, 1'b0); cyc();
    chk("t4_out8", 32'(o_outstanding), 32'd8);
    chk("t4_block8", 32'(o_ar_block), 32'd1);
    // Full queue: push and closing beat together is not an overflow
    drive(1'b1, 8'd0, 1'b1, 1'b1); cyc();
    chk("t5_out", 32'(o_outstanding), 32'd8);
    chk("t5_err", 32'(o_err), 32'd0);
    chk("t5_done", 32'(o_burst_done), 32'd1);
    chk("t5_block", 32'(o_ar_block), 32'd1);
    // Push into full queue alone overflows
    drive(1'b1, 8'd0, 1'b0, 1'b0); cyc();
    chk("t4_ovf_err", 32'(o_err), 32'h4);
    chk("t4_ovf_out", 32'(o_outstanding), 32'd8);
    // A pop alone releases the block
    drive(1'b0, 8'd0, 1'b1, 1'b1); cyc();
    chk("t4_pop_out", 32'(o_outstanding), 32'd7);
    chk("t4_pop_block", 32'(o_ar_block), 32'd0);
    do_start();
    chk("t4_start_out", 32'(o_outstanding), 32'd0);

    // Beat with empty queue
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    chk("t6_unexp_err", 32'(o_err), 32'h8);
    chk("t6_unexp_cnt", 32'(o_beat_cnt), 32'd0);
    do_start();
    chk("t6_start_err", 32'(o_err), 32'd0);
    chk("t6_start_out", 32'(o_outstanding), 32'd0);

    // No bypass: beat alongside the first AR into an empty queue
    drive(1'b1, 8'd0, 1'b1, 1'b1); cyc();
    chk("t7_bypass_err", 32'(o_err), 32'h8);
    chk("t7_bypass_out", 32'(o_outstanding), 32'd1);
    chk("t7_bypass_done", 32'(o_burst_done), 32'd0);

    // Start overrides concurrent handshakes
    drive(1'b1, 8'd2, 1'b1, 1'b1);
    do_start();
    chk("t8_start_out", 32'(o_outstanding), 32'd0);
    chk("t8_start_err", 32'(o_err), 32'd0);
    chk("t8_start_done", 32'(o_burst_done), 32'd0);

    // Asynchronous reset mid-burst
    drive(1'b1, 8'd3, 1'b0, 1'b0); cyc();
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    drive(1'b0, 8'd0, 1'b1, 1'b0); cyc();
    chk("t9_pre_cnt", 32'(o_beat_cnt), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t9_rst_cnt", 32'(o_beat_cnt), 32'd0);
    chk("t9_rst_out", 32'(o_outstanding), 32'd0);
    chk("t9_rst_err", 32'(o_err), 32'd0);
    chk("t9_rst_block", 32'(o_ar_block), 32'd0);
    chk("t9_rst_done", 32'(o_burst_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // After reset a stray beat finds an empty queue
    drive(1'b0, 8'd0, 1'b1, 1'b1); cyc();
    chk("t9_post_err", 32'(o_err), 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_rlast_checker.md
Name: axi_rlast_checker

Overview:
- Receiver-side counterpart of our AXI write-last generator.
- Snoops the AR channel and queues each requested burst length (ARLEN).
- Counts R-channel handshakes against the head-of-queue length, checks that RLAST arrives exactly on the final beat, and flags protocol errors.
- Sits between the host-memory AXI read port and the decompressor input buffer, as a passive monitor plus a burst-complete pulse source.

Parameters:
- LEN_W, 8, width of AXI burst length field (ARLEN = beats-1)
- DEPTH, 8, max outstanding bursts tracked; power of 2, >= 2
- CNT_W, 8, beat counter width; must be >= LEN_W

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  synchronous clear of queue, counter and sticky errors
- ar_valid  in  1  AR channel valid (snooped)
- ar_ready  in  1  AR channel ready (snooped)
- ar_len  in  LEN_W  ARLEN of request
- r_valid  in  1  R channel valid (snooped)
- r_ready  in  1  R channel ready (snooped)
- r_last  in  1  RLAST
- ar_block  out  1  queue full; upstream must hold ar_valid low while set
- burst_done  out  1  one-cycle pulse per burst closed (correct or errored)
- beat_cnt  out  CNT_W  beats received in the current burst
- outstanding  out  $clog2(DEPTH)+1  bursts queued, not yet closed
- err  out  4  sticky: [0] early_last, [1] missing_last, [2] overflow, [3] unexpected_beat

Behaviour:
- Reset (async, rst=1): queue empty; beat_cnt=0; outstanding=0; burst_done=0; err=0; ar_block=0.
- All outputs are registered and update on the clock edge after the triggering handshake.
- Priority: rst > start > handshakes. While start=1, all handshakes in that cycle are ignored and state clears as for reset.
- AR push: occurs when ar_valid & ar_ready.
  - If the queue is full, set err[2]; the length is dropped; no other state changes.
- R beat: occurs when r_valid & r_ready, with head length L.
  - Queue empty: set err[3], ignore the beat; beat_cnt unchanged.
  - beat_cnt < L and r_last=0: beat_cnt++.
  - beat_cnt < L and r_last=1: set err[0], pop, beat_cnt=0, burst_done=1.
  - beat_cnt == L and r_last=1: good close. Pop, beat_cnt=0, burst_done=1.
  - beat_cnt == L and r_last=0: set err[1], pop, beat_cnt=0, burst_done=1. Later beats count toward the next queued burst (resync).
- Simultaneous push and pop in the same cycle: both take effect and outstanding is unchanged. A push into a full queue concurrent with a pop succeeds; full is evaluated after the pop.
- No bypass: an R beat in the same cycle as the first AR push into an empty queue sets err[3].
- ar_block = (outstanding == DEPTH), registered.
- L = 0 (single-beat burst): the first beat must carry r_last.
- Width wrap: beat_cnt never exceeds L, so there is no wrap when CNT_W >= LEN_W.
- Errors are sticky until start or rst.
- Reset asserted mid-burst discards all tracking immediately.

Optional Feature:
- Macro: RLAST_CHK_STATS_EN
- Defined:
  - Adds outputs stat_bursts[31:0] (good closes only) and stat_beats[31:0] (all accepted beats, excluding err[3] beats).
  - Both counters wrap modulo 2^32 and clear on rst or start.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package axi_chk_pkg holds:
  - AXI_LEN_W constant
  - error bit index constants ERR_EARLY_LAST=0, ERR_MISSING_LAST=1, ERR_OVERFLOW=2, ERR_UNEXPECTED=3
- Sub-module burst_len_fifo: synchronous FIFO, width LEN_W, depth DEPTH.
  - Ports: push, pop, din, dout (head, combinational), count, full, empty.
  - Async active-high reset; synchronous clear driven by start.

Test Plan:
- Push ar_len=3, then 4 beats with r_last on the 4th -> burst_done pulses once one cycle after beat 4; err=0; outstanding 1->0.
- Push ar_len=7, r_last on the 3rd beat -> err[0]=1, burst_done pulse, beat_cnt=0, outstanding=0.
- Push lens 1 and 0; send 2 beats without r_last, then 1 beat with r_last -> err[1]=1 on beat 2; second burst closes cleanly; two burst_done pulses.
- DEPTH=8: 9 back-to-back AR handshakes, no R traffic -> ar_block=1 after the 8th; err[2]=1 after the 9th; outstanding=8.
- Queue full: AR push and a final R beat in the same cycle -> no overflow; outstanding stays 8.
- R beat with an empty queue -> err[3]=1, beat_cnt stays 0. Then start=1 for one cycle -> err=0, outstanding=0. Assert rst mid-burst -> all outputs 0 asynchronously.
